dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline load/store port (requester 0, "cpu") and a program/data loader or debug port (requester 1, "ld").
- Sits between riscVpipeline/loader and dmem (async read, sync write).
- Provides round-robin ownership, a burst cap for fairness, muxed memory drive, and registered read-data return with per-requester valid.

Parameters:
- ADDR_W, 32, address width of both requesters and memory port.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive accesses by one owner while the other requests (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  cpu access request, held until granted beat
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_gnt  out  1  cpu owns port; access occurs in cycles with cpu_req&&cpu_gnt
- cpu_rdata  out  DATA_W  registered read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rdata, ld_rvalid  same as cpu_* for loader
- mem_we  out  1  to dmem.we
- mem_a  out  ADDR_W  to dmem.a
- mem_wd  out  DATA_W  to dmem.wd
- mem_rd  in  DATA_W  from dmem.rd (combinational read)
- stat_cpu_cnt, stat_ld_cnt, stat_conflict_cnt  out  32  statistics (see Optional Feature)

Behaviour:
- Clocking: one clock (clk); reset synchronous, active-high; all state updates on posedge clk.
- Reset values: state=IDLE, last_owner=LD (cpu wins first tie), burst_cnt=0, *_gnt=0, *_rvalid=0, *_rdata=0, stat counters=0. mem_* are combinational and therefore 0 while in IDLE.
- States: IDLE, OWN_CPU, OWN_LD. Gnt is a registered decode: cpu_gnt=(state==OWN_CPU), ld_gnt=(state==OWN_LD).
- IDLE: if exactly one req, go to that owner. If both, go to the requester != last_owner. Otherwise stay. Request-to-grant latency is 1 cycle.
- Beat: cycle with own req && own gnt. It drives mem_a/mem_wd from the owner and mem_we=owner_we, and increments burst_cnt (saturating at MAX_BURST).
- Non-beat cycles: mem_we=0, mem_a=0, mem_wd=0.
- Read beat: mem_rd is captured into the owner's rdata register. The owner's rvalid pulses the next cycle (latency 1). Write beats produce no rvalid.
- Release: if the owner drops req, go to the other owner if it is requesting (no idle bubble), else go to IDLE. Set last_owner=owner and burst_cnt=0.
- Forced switch: if burst_cnt reaches MAX_BURST after a beat and the other requester is requesting, switch to the other owner. The owner's next request waits at least one cycle.
- No forced switch without contention; an uncontended owner keeps the port indefinitely, with burst_cnt saturated.
- Back-to-back beats by the same owner are allowed every cycle.
- rdata holds its value until the next read beat of that requester.
- Gnt changes only at clock edges. A requester whose gnt falls has not had an access in that cycle.
- Reset mid-burst: grant is dropped immediately at the edge and a pending rvalid is cancelled. A write beat in the reset cycle still reaches dmem, since mem_we is combinational; the bench must hold req low during reset.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - stat_cpu_cnt and stat_ld_cnt increment on each beat of that requester.
  - stat_conflict_cnt increments each cycle the non-owner requests while the port is owned or being arbitrated in IDLE.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: the stat ports are tied to 0 and no counter flops are built.

Decomposition:
- Package arb_pkg:
  - enum arb_state_t {IDLE, OWN_CPU, OWN_LD};
  - enum owner_t {OWN_CPU_ID, OWN_LD_ID};
  - localparam BURST_CNT_W=8.
- One natural sub-module rr_pick2: two req inputs plus last_owner in, chosen owner and valid out, purely combinational. The top instantiates it for both the IDLE and release decisions.

Test Plan:
- Reset then cpu_req=1, cpu_we=0, cpu_addr=0x10, with dmem[0x10]=0xDEADBEEF → cpu_gnt=1 at cycle 1; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF at cycle 2; ld_gnt stays 0.
- Both req asserted in IDLE right after reset → cpu granted first. Cpu drops req after 1 beat → ld_gnt next cycle, no IDLE bubble.
- ld writing continuously to 0x100..; cpu_req raised at ld beat 1, MAX_BURST=4 → exactly 4 ld beats, then cpu_gnt. ld regains the port after cpu releases, and mem_we never pulses while gnt=0.
- ld alone streams 10 writes with no cpu_req → 10 consecutive beats with no forced switch; dmem holds all 10 values.
- reset asserted while OWN_LD with a read beat in flight → next cycle ld_gnt=0, ld_rvalid=0, state IDLE.
- ARB_STATS_EN defined: 3 cpu beats, 5 ld beats, 2 contended cycles → stat_cpu_cnt=3, stat_ld_cnt=5, stat_conflict_cnt=2. Undefined: all three read 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types and helpers for the data-memory port arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_LD  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU_ID = 1'b0,
        OWN_LD_ID  = 1'b1
    } owner_t;

    localparam int BURST_CNT_W = 8;

    // Saturating burst counter step; once at the cap the owner stays there until it leaves.
    function automatic logic [BURST_CNT_W-1:0] burst_inc(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] cap
    );
        if (cnt >= cap) begin
            return cap;
        end
        return cnt + 8'd1;
    endfunction

    // Ownership state that corresponds to a requester id.
    function automatic arb_state_t owner_to_state(input owner_t who);
        return (who == OWN_LD_ID) ? OWN_LD : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// rtl/dmem_port_arbiter_rr_pick2.sv - two-way round-robin pick, combinational
module rr_pick2
    import arb_pkg::*;
(
    input  logic   req_cpu,
    input  logic   req_ld,
    input  owner_t last_owner,
    output owner_t pick,
    output logic   pick_valid
);

    // A lone requester wins outright; on a tie the one that did not own last goes first.
    always_comb begin
        pick       = OWN_CPU_ID;
        pick_valid = req_cpu | req_ld;
        if (req_cpu && req_ld) begin
            pick = (last_owner == OWN_CPU_ID) ? OWN_LD_ID : OWN_CPU_ID;
        end else if (req_ld) begin
            pick = OWN_LD_ID;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin cpu/loader arbiter for one dmem port (optional ARB_STATS_EN statistics)
module dmem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [31:0]       stat_cpu_cnt,
    output logic [31:0]       stat_ld_cnt,
    output logic [31:0]       stat_conflict_cnt
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

    arb_state_t             state;
    arb_state_t             state_nxt;
    owner_t                 last_owner;
    owner_t                 last_owner_nxt;
    owner_t                 cur_owner;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] burst_cnt_nxt;
    logic [BURST_CNT_W-1:0] burst_after;
    logic                   cpu_beat;
    logic                   ld_beat;
    logic                   owner_req;
    owner_t                 idle_pick;
    logic                   idle_valid;
    owner_t                 hand_pick;
    logic                   hand_valid;

    assign cpu_gnt   = (state == OWN_CPU);
    assign ld_gnt    = (state == OWN_LD);
    assign cpu_beat  = cpu_req & cpu_gnt;
    assign ld_beat   = ld_req & ld_gnt;
    assign cur_owner = ld_gnt ? OWN_LD_ID : OWN_CPU_ID;
    assign owner_req = ld_gnt ? ld_req : cpu_req;

    // Arbitration from IDLE: both requests compete against last_owner.
    rr_pick2 u_pick_idle (
        .req_cpu    (cpu_req),
        .req_ld     (ld_req),
        .last_owner (last_owner),
        .pick       (idle_pick),
        .pick_valid (idle_valid)
    );

    // Hand-off from an owner: the owner's own request is masked so only the other side can win.
    rr_pick2 u_pick_hand (
        .req_cpu    (cpu_req & ~cpu_gnt),
        .req_ld     (ld_req & ~ld_gnt),
        .last_owner (cur_owner),
        .pick       (hand_pick),
        .pick_valid (hand_valid)
    );

    // Only a beat reaches dmem; everything else parks the port at zero.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (cpu_beat) begin
            mem_we = cpu_we;
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
        end else if (ld_beat) begin
            mem_we = ld_we;
            mem_a  = ld_addr;
            mem_wd = ld_wdata;
        end
    end

    // Ownership next-state: release on dropped req, forced hand-off at the burst cap under contention.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        burst_after    = burst_inc(burst_cnt, BURST_MAX);
        case (state)
            IDLE: begin
                if (idle_valid) begin
                    state_nxt = owner_to_state(idle_pick);
                end
            end
            OWN_CPU, OWN_LD: begin
                if (!owner_req) begin
                    last_owner_nxt = cur_owner;
                    burst_cnt_nxt  = '0;
                    state_nxt      = hand_valid ? owner_to_state(hand_pick) : IDLE;
                end else if ((burst_after >= BURST_MAX) && hand_valid) begin
                    last_owner_nxt = cur_owner;
                    burst_cnt_nxt  = '0;
                    state_nxt      = owner_to_state(hand_pick);
                end else begin
                    burst_cnt_nxt = burst_after;
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    // Ownership state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWN_LD_ID;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // Read-data return: capture dmem on a read beat, pulse that requester's rvalid one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
            cpu_rvalid <= 1'b0;
            ld_rvalid  <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_beat & ~cpu_we;
            ld_rvalid  <= ld_beat & ~ld_we;
            if (cpu_beat && !cpu_we) begin
                cpu_rdata <= mem_rd;
            end
            if (ld_beat && !ld_we) begin
                ld_rdata <= mem_rd;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] cpu_cnt_q;
    logic [31:0] ld_cnt_q;
    logic [31:0] conflict_cnt_q;
    logic        conflict;

    assign conflict = (cpu_gnt & ld_req) | (ld_gnt & cpu_req) |
                      ((state == IDLE) & cpu_req & ld_req);

    // Beat and contention counters; free-running, wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_cnt_q      <= '0;
            ld_cnt_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (cpu_beat) begin
                cpu_cnt_q <= cpu_cnt_q + 32'd1;
            end
            if (ld_beat) begin
                ld_cnt_q <= ld_cnt_q + 32'd1;
            end
            if (conflict) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign stat_cpu_cnt      = cpu_cnt_q;
    assign stat_ld_cnt       = ld_cnt_q;
    assign stat_conflict_cnt = conflict_cnt_q;
`else
    assign stat_cpu_cnt      = '0;
    assign stat_ld_cnt       = '0;
    assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed plus random check of dmem_port_arbiter against a reference model
module tb_dmem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req, cpu_we, ld_req, ld_we;
    logic [ADDR_W-1:0] cpu_addr, ld_addr;
    logic [DATA_W-1:0] cpu_wdata, ld_wdata;
    logic              cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid;
    logic [DATA_W-1:0] cpu_rdata, ld_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd, mem_rd;
    logic [31:0]       stat_cpu_cnt, stat_ld_cnt, stat_conflict_cnt;

    logic              r_req  [2];
    logic              r_we   [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_wd   [2];

    assign cpu_req   = r_req[0];
    assign cpu_we    = r_we[0];
    assign cpu_addr  = r_addr[0];
    assign cpu_wdata = r_wd[0];
    assign ld_req    = r_req[1];
    assign ld_we     = r_we[1];
    assign ld_addr   = r_addr[1];
    assign ld_wdata  = r_wd[1];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_gnt           (cpu_gnt),
        .cpu_rdata         (cpu_rdata),
        .cpu_rvalid        (cpu_rvalid),
        .ld_req            (ld_req),
        .ld_we             (ld_we),
        .ld_addr           (ld_addr),
        .ld_wdata          (ld_wdata),
        .ld_gnt            (ld_gnt),
        .ld_rdata          (ld_rdata),
        .ld_rvalid         (ld_rvalid),
        .mem_we            (mem_we),
        .mem_a             (mem_a),
        .mem_wd            (mem_wd),
        .mem_rd            (mem_rd),
        .stat_cpu_cnt      (stat_cpu_cnt),
        .stat_ld_cnt       (stat_ld_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
    );

    logic [DATA_W-1:0] dmem [0:1023];
    assign mem_rd = dmem[mem_a[9:0]];

    // Reference model: owner -1 = nobody, 0 = cpu, 1 = loader.
    int          m_own;
    int          m_last;
    int          m_cnt;
    logic [31:0] m_mem   [0:1023];
    logic [31:0] m_rdata [2];
    logic        m_rv    [2];
    logic [31:0] m_stat  [3];
    logic        done    [2];
    logic        pend    [2];
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: inputs already set; compare outputs mid-cycle, advance the model, cross the edge.
    task automatic step(input logic rst);
        int          o;
        int          oth;
        logic        beat;
        logic        e_we;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        logic [31:0] e_stat [3];
        logic        w_en;
        logic [9:0]  w_a;
        logic [31:0] w_d;
        reset = rst;
        #3;
        o    = m_own;
        oth  = 1 - o;
        beat = (!rst && o >= 0) ? r_req[o] : 1'b0;
        e_we = 1'b0;
        e_a  = '0;
        e_wd = '0;
        if (beat) begin
            e_we = r_we[o];
            e_a  = r_addr[o];
            e_wd = r_wd[o];
        end
`ifdef ARB_STATS_EN
        for (int i = 0; i < 3; i++) e_stat[i] = m_stat[i];
`else
        for (int i = 0; i < 3; i++) e_stat[i] = '0;
`endif
        if (chk_en) begin
            check_eq("cpu_gnt", cpu_gnt, m_own == 0);
            check_eq("ld_gnt", ld_gnt, m_own == 1);
            check_eq("cpu_rvalid", cpu_rvalid, m_rv[0]);
            check_eq("ld_rvalid", ld_rvalid, m_rv[1]);
            check_eq("cpu_rdata", cpu_rdata, m_rdata[0]);
            check_eq("ld_rdata", ld_rdata, m_rdata[1]);
            check_eq("mem_we", mem_we, e_we);
            check_eq("mem_a", mem_a, e_a);
            check_eq("mem_wd", mem_wd, e_wd);
            check_eq("stat_cpu", stat_cpu_cnt, e_stat[0]);
            check_eq("stat_ld", stat_ld_cnt, e_stat[1]);
            check_eq("stat_conflict", stat_conflict_cnt, e_stat[2]);
        end
        w_en = mem_we;
        w_a  = mem_a[9:0];
        w_d  = mem_wd;

        done[0] = 1'b0;
        done[1] = 1'b0;
        if (rst) begin
            m_own  = -1;
            m_last = 1;
            m_cnt  = 0;
            for (int i = 0; i < 2; i++) begin
                m_rv[i]    = 1'b0;
                m_rdata[i] = '0;
            end
            for (int i = 0; i < 3; i++) m_stat[i] = '0;
        end else begin
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            if (beat) begin
                done[o]   = 1'b1;
                m_stat[o] = m_stat[o] + 32'd1;
                if (r_we[o]) begin
                    m_mem[r_addr[o][9:0]] = r_wd[o];
                end else begin
                    m_rdata[o] = m_mem[r_addr[o][9:0]];
                    m_rv[o]    = 1'b1;
                end
            end
            if (o >= 0) begin
                if (r_req[oth]) m_stat[2] = m_stat[2] + 32'd1;
            end else if (r_req[0] && r_req[1]) begin
                m_stat[2] = m_stat[2] + 32'd1;
            end
            if (o < 0) begin
                if (r_req[0] && r_req[1]) m_own = 1 - m_last;
                else if (r_req[0])        m_own = 0;
                else if (r_req[1])        m_own = 1;
            end else if (!r_req[o]) begin
                m_last = o;
                m_cnt  = 0;
                m_own  = r_req[oth] ? oth : -1;
            end else begin
                m_cnt = (m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1;
                if (m_cnt >= MAX_BURST && r_req[oth]) begin
                    m_last = o;
                    m_own  = oth;
                    m_cnt  = 0;
                end
            end
        end

        @(posedge clk);
        if (w_en) dmem[w_a] = w_d;
        #1;
        cyc++;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0;
            r_we[i]  = 1'b0;
            pend[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        step(1'b1);
    endtask

    int          k;
    int          n;
    int          first_c;
    int          last_c;
    int          ld_beats;
    int          mism;
    logic [31:0] vals [10];
    logic [31:0] v;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            v        = $urandom;
            dmem[i]  = v;
            m_mem[i] = v;
        end
        dmem[16]  = 32'hDEADBEEF;
        m_mem[16] = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0;
            r_wd[i]   = '0;
        end
        idle_all();
        step(1'b1);
        chk_en = 1'b1;
        step(1'b1);
        step(1'b0);

        // single cpu read of 0x10
        do_reset();
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h10;
        step(1'b0);
        check_eq("tp1_cpu_gnt_c1", cpu_gnt, 1'b1);
        check_eq("tp1_ld_gnt_c1", ld_gnt, 1'b0);
        step(1'b0);
        r_req[0] = 1'b0;
        check_eq("tp1_rvalid_c2", cpu_rvalid, 1'b1);
        check_eq("tp1_rdata_c2", cpu_rdata, 32'hDEADBEEF);
        check_eq("tp1_ld_gnt_c2", ld_gnt, 1'b0);
        step(1'b0);
        step(1'b0);

        // tie after reset goes to cpu, release hands straight to ld
        do_reset();
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = $urandom_range(0, 1023);
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = $urandom_range(0, 1023);
        step(1'b0);
        check_eq("tp2_cpu_first", cpu_gnt, 1'b1);
        check_eq("tp2_ld_wait", ld_gnt, 1'b0);
        step(1'b0);
        r_req[0] = 1'b0;
        step(1'b0);
        check_eq("tp2_no_bubble", ld_gnt, 1'b1);
        step(1'b0);
        r_req[1] = 1'b0;
        step(1'b0);
        step(1'b0);

        // burst cap: ld streams writes, cpu contends after the first ld beat
        do_reset();
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h100; r_wd[1] = $urandom;
        ld_beats = 0;
        k = 0;
        while (!cpu_gnt && k < 30) begin
            if (ld_req && ld_gnt) ld_beats++;
            step(1'b0);
            if (done[1]) begin
                r_addr[1] = r_addr[1] + 32'd1;
                r_wd[1]   = $urandom;
                if (r_addr[1] == 32'h101) begin
                    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = $urandom_range(0, 1023);
                end
            end
            k++;
        end
        check_eq("tp3_cpu_granted", cpu_gnt, 1'b1);
        check_eq("tp3_ld_burst", ld_beats, MAX_BURST);
        k = 0;
        while (!ld_gnt && k < 10) begin
            step(1'b0);
            if (done[0]) r_req[0] = 1'b0;
            k++;
        end
        check_eq("tp3_ld_regains", ld_gnt, 1'b1);
        step(1'b0);
        r_req[1] = 1'b0;
        step(1'b0);
        step(1'b0);

        // uncontended stream of 10 ld writes
        do_reset();
        for (int i = 0; i < 10; i++) vals[i] = $urandom;
        n = 0; first_c = -1; last_c = -1; k = 0;
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h200; r_wd[1] = vals[0];
        while (n < 10 && k < 40) begin
            step(1'b0);
            if (done[1]) begin
                if (n == 0) first_c = cyc;
                last_c = cyc;
                n++;
                if (n < 10) begin
                    r_addr[1] = 32'h200 + 32'(n);
                    r_wd[1]   = vals[n];
                end else begin
                    r_req[1] = 1'b0;
                end
            end
            k++;
        end
        check_eq("tp4_beats", n, 10);
        check_eq("tp4_consecutive", last_c - first_c, 9);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 10; i++) check_eq("tp4_dmem", dmem[10'h200 + i], vals[i]);

        // reset with a loader read return pending
        do_reset();
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = $urandom_range(0, 1023);
        k = 0;
        while (!done[1] && k < 10) begin
            step(1'b0);
            k++;
        end
        check_eq("tp5_read_beat", done[1], 1'b1);
        r_req[1] = 1'b0;
        check_eq("tp5_rvalid_pending", ld_rvalid, 1'b1);
        step(1'b1);
        check_eq("tp5_gnt_dropped", ld_gnt, 1'b0);
        check_eq("tp5_rvalid_cancel", ld_rvalid, 1'b0);
        step(1'b0);

        // random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i]   = 1'b1;
                    r_we[i]   = 1'($urandom_range(0, 1));
                    r_addr[i] = $urandom_range(0, 1023);
                    r_wd[i]   = $urandom;
                end
                r_req[i] = pend[i];
            end
            if ($urandom_range(0, 249) == 0) begin
                idle_all();
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        idle_all();
        step(1'b0);
        step(1'b0);

        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            if (dmem[i] !== m_mem[i]) mism++;
        end
        check_eq("dmem_image", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
